psw_context_stack: RTL and testbench

- Parametrised successor to the program status register.
- Holds the live PSW with masked flag updates and byte-lane software writes.
- Adds a hardware LIFO of saved PSWs: exception/interrupt entry pushes the live PSW and loads a new one; return-from-exception pops it back.
- Sits beside the control unit; `psw_out` feeds the ALU condition logic and the interrupt priority comparator.

---
 rtl/psw_pkg.sv | 31 +++
 rtl/psw_context_stack_if.sv | 41 ++++
 rtl/psw_lifo.sv | 71 +++++++
 rtl/psw_context_stack.sv | 99 +++++++++
 tb/tb_psw_context_stack.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/psw_pkg.sv
// Shared definitions for the PSW context stack.
//   flag_e      : index of each ALU flag within the low-order PSW bits
//   status_t    : packed view of the four ALU flags (V N Z C, C in bit 0)
//   level_width : width of an occupancy counter that must hold 0..depth
package psw_pkg;

    typedef enum logic [1:0] {
        FlagC = 2'd0,
        FlagZ = 2'd1,
        FlagN = 2'd2,
        FlagV = 2'd3
    } flag_e;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } status_t;

    localparam int unsigned NumFlags     = 4;
    localparam int unsigned DefaultDepth = 4;

    // Counter must represent DEPTH itself, hence depth + 1 states.
    function automatic int unsigned level_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    localparam int unsigned DefaultLevelW = level_width(DefaultDepth);

endpackage

// File: rtl/psw_context_stack_if.sv
// Control-unit side bundle for psw_context_stack.
//   master : control unit / bench; drives strobes and data, observes state
//   slave  : psw_context_stack; consumes strobes, drives psw_out/level/flags
interface psw_context_stack_if
    import psw_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FLAG_BITS = 4,
    parameter int unsigned DEPTH     = 4
);

    localparam int unsigned LevelW = level_width(DEPTH);

    logic                 status_wr;
    logic [FLAG_BITS-1:0] status_wr_mode;
    logic [FLAG_BITS-1:0] status_in;
    logic [WIDTH/8-1:0]   wr_en;
    logic [WIDTH-1:0]     wr_data;
    logic                 push;
    logic [WIDTH-1:0]     push_data;
    logic                 pop;
    logic [WIDTH-1:0]     psw_out;
    logic [LevelW-1:0]    level;
    logic                 full;
    logic                 empty;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output status_wr, status_wr_mode, status_in, wr_en, wr_data,
               push, push_data, pop,
        input  psw_out, level, full, empty, overflow_err, underflow_err
    );

    modport slave (
        input  status_wr, status_wr_mode, status_in, wr_en, wr_data,
               push, push_data, pop,
        output psw_out, level, full, empty, overflow_err, underflow_err
    );

endinterface

// File: rtl/psw_lifo.sv
// Register-array LIFO with occupancy tracking; knows nothing about PSW meaning.
//   clk, rst    : clock, asynchronous active-high reset (clears level only)
//   push_i      : store push_data_i on top (ignored when full)
//   pop_i       : drop top entry (ignored when empty or when push_i is set)
//   push_data_i : value to store
//   top_o       : current top entry (undefined when empty)
//   level_o     : number of occupied entries
//   full_o      : level_o == DEPTH
//   empty_o     : level_o == 0
module psw_lifo
    import psw_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              push_data_i,
    output logic [WIDTH-1:0]              top_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int unsigned LevelW = level_width(DEPTH);
    localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned Slots  = 2 ** IdxW;

    logic [WIDTH-1:0]  mem_q [Slots];
    logic [LevelW-1:0] level_q, level_d;
    logic [IdxW-1:0]   wr_idx, rd_idx;
    logic              do_push, do_pop;

    always_comb begin
        full_o  = (level_q == LevelW'(DEPTH));
        empty_o = (level_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !push_i && !empty_o;
        // level < DEPTH <= Slots whenever it is used as an index, so the
        // truncation and the modulo decrement below are both exact.
        wr_idx  = level_q[IdxW-1:0];
        rd_idx  = wr_idx - IdxW'(1);
        top_o   = mem_q[rd_idx];
        level_d = level_q;
        if (do_push) begin
            level_d = level_q + LevelW'(1);
        end else if (do_pop) begin
            level_d = level_q - LevelW'(1);
        end
    end

    assign level_o = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/psw_context_stack.sv
// Live program status word with a hardware stack of saved contexts.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : psw_context_stack_if.slave
//              status_wr/status_wr_mode/status_in : masked flag update
//              wr_en/wr_data                      : byte-lane software write
//              push/push_data                     : exception entry
//              pop                                : exception return
//              psw_out, level, full, empty        : registered state
//              overflow_err/underflow_err         : one-cycle refusal pulses
// One action per cycle, priority push > pop > status_wr > wr_en.
// WIDTH must be a multiple of 8 and DEPTH at least 1.
module psw_context_stack
    import psw_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      FLAG_BITS = NumFlags,
    parameter int unsigned      DEPTH     = DefaultDepth,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    psw_context_stack_if.slave bus
);

    localparam int unsigned Lanes = WIDTH / 8;

    logic [WIDTH-1:0] psw_q, psw_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] lifo_top;
    logic             lifo_full, lifo_empty;

    // The LIFO gates push on full and pop on empty/push itself; the same
    // conditions are repeated here only to decide the PSW and error pulses.
    psw_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.push),
        .pop_i       (bus.pop),
        .push_data_i (psw_q),
        .top_o       (lifo_top),
        .level_o     (bus.level),
        .full_o      (lifo_full),
        .empty_o     (lifo_empty)
    );

    always_comb begin
        psw_d = psw_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (bus.push) begin
            if (lifo_full) begin
                ovf_d = 1'b1;
            end else begin
                psw_d = bus.push_data;
            end
        end else if (bus.pop) begin
            if (lifo_empty) begin
                unf_d = 1'b1;
            end else begin
                psw_d = lifo_top;
            end
        end else if (bus.status_wr) begin
            for (int i = 0; i < FLAG_BITS; i++) begin
                if (bus.status_wr_mode[i]) begin
                    psw_d[i] = bus.status_in[i];
                end
            end
        end else begin
            for (int k = 0; k < Lanes; k++) begin
                if (bus.wr_en[k]) begin
                    psw_d[8*k +: 8] = bus.wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psw_q <= RESET_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            psw_q <= psw_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.psw_out       = psw_q;
    assign bus.full          = lifo_full;
    assign bus.empty         = lifo_empty;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_psw_context_stack.sv
module tb_psw_context_stack;

    localparam int unsigned W  = 16;
    localparam int unsigned FB = 4;
    localparam int unsigned D  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psw_context_stack_if #(.WIDTH(W), .FLAG_BITS(FB), .DEPTH(D)) bus ();

    psw_context_stack #(
        .WIDTH     (W),
        .FLAG_BITS (FB),
        .DEPTH     (D),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        sw;
        logic [3:0]  mode;
        logic [3:0]  sin;
        logic [1:0]  wen;
        logic [15:0] wdata;
        logic        push;
        logic [15:0] pdata;
        logic        pop;
        logic [15:0] e_psw;
        int          e_lvl;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model state
    logic [15:0] m_psw;
    logic [15:0] m_stk[$];
    logic        m_ovf, m_unf;

    function automatic vec_t mk(input logic sw, input logic [3:0] mode, input logic [3:0] sin,
                                input logic [1:0] wen, input logic [15:0] wdata,
                                input logic push, input logic [15:0] pdata, input logic pop,
                                input logic [15:0] e_psw, input int e_lvl,
                                input logic e_ovf, input logic e_unf);
        vec_t v;
        v.sw = sw; v.mode = mode; v.sin = sin; v.wen = wen; v.wdata = wdata;
        v.push = push; v.pdata = pdata; v.pop = pop;
        v.e_psw = e_psw; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] epsw, input int elvl,
                              input logic eovf, input logic eunf);
        chk({tag, " psw_out"}, 32'(bus.psw_out), 32'(epsw));
        chk({tag, " level"}, 32'(bus.level), 32'(elvl));
        chk({tag, " full"}, 32'(bus.full), 32'(elvl == int'(D)));
        chk({tag, " empty"}, 32'(bus.empty), 32'(elvl == 0));
        chk({tag, " overflow_err"}, 32'(bus.overflow_err), 32'(eovf));
        chk({tag, " underflow_err"}, 32'(bus.underflow_err), 32'(eunf));
    endtask

    task automatic drive(input vec_t v);
        bus.status_wr      = v.sw;
        bus.status_wr_mode = v.mode;
        bus.status_in      = v.sin;
        bus.wr_en          = v.wen;
        bus.wr_data        = v.wdata;
        bus.push           = v.push;
        bus.push_data      = v.pdata;
        bus.pop            = v.pop;
    endtask

    task automatic idle();
        drive(mk(0, 4'h0, 4'h0, 2'b00, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level model: one action per cycle, stack as a queue.
    task automatic model_update();
        logic [15:0] fmask, bmask;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (bus.push) begin
            if (m_stk.size() == int'(D)) m_ovf = 1'b1;
            else begin
                m_stk.push_back(m_psw);
                m_psw = bus.push_data;
            end
        end else if (bus.pop) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else m_psw = m_stk.pop_back();
        end else if (bus.status_wr) begin
            fmask = {12'h000, bus.status_wr_mode};
            m_psw = (m_psw & ~fmask) | ({12'h000, bus.status_in} & fmask);
        end else begin
            bmask = {{8{bus.wr_en[1]}}, {8{bus.wr_en[0]}}};
            m_psw = (m_psw & ~bmask) | (bus.wr_data & bmask);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        step();
        check_outs("reset", 16'h0000, 0, 0, 0);
        step();
        #3;
        rst = 1'b0;
        step();

        // sw, mode, sin, wen, wdata, push, pdata, pop, e_psw, e_lvl, e_ovf, e_unf
        vecs.push_back(mk(1, 4'b0101, 4'b1111, 2'b00, 16'h0000, 0, 16'h0000, 0, 16'h0005, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1010, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 0, 16'h0005, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b10, 16'hABCD, 0, 16'h0000, 0, 16'hAB05, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b11, 16'h0005, 0, 16'h0000, 0, 16'h0005, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0001, 4'b0000, 2'b10, 16'hABCD, 0, 16'h0000, 0, 16'h0004, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b11, 16'h1111, 0, 16'h0000, 0, 16'h1111, 0, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 2'b00, 16'h0000, 1, 16'h2222, 0, 16'h2222, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 1, 16'h3333, 0, 16'h3333, 2, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 1, 16'h4444, 0, 16'h4444, 3, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 1, 16'h5555, 0, 16'h5555, 4, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 1, 16'h6666, 0, 16'h5555, 4, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 0, 16'h5555, 4, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h4444, 3, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h3333, 2, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h2222, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h1111, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h1111, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 1, 16'h00AA, 0, 16'h00AA, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 1, 16'h00F0, 1, 16'h00F0, 2, 0, 0));
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 2'b11, 16'hFFFF, 0, 16'h0000, 1, 16'h00AA, 1, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h1111, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 16'h0000, 0, 16'h0000, 0, 16'h1111, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_psw, vecs[i].e_lvl,
                       vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Asynchronous reset while three contexts are saved.
        drive(mk(0, 4'h0, 4'h0, 2'b00, 16'h0, 1, 16'h0A0A, 0, 16'h0, 0, 0, 0));
        step();
        bus.push_data = 16'h0B0B;
        step();
        bus.push_data = 16'h0C0C;
        step();
        check_outs("nest3", 16'h0C0C, 3, 0, 0);
        idle();
        #3;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 16'h0000, 0, 0, 0);
        #2;
        rst = 1'b0;
        bus.pop = 1'b1;
        step();
        check_outs("pop_after_rst", 16'h0000, 0, 0, 1);
        idle();
        step();
        check_outs("idle_after_rst", 16'h0000, 0, 0, 0);

        // Randomised phase against the reference model.
        m_psw = 16'h0000;
        m_stk.delete();
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.push           = (r < 25);
            bus.pop            = (r >= 20 && r < 50);
            bus.status_wr      = ($urandom_range(0, 2) == 0);
            bus.status_wr_mode = 4'($urandom);
            bus.status_in      = 4'($urandom);
            bus.wr_en          = 2'($urandom);
            bus.wr_data        = 16'($urandom);
            bus.push_data      = 16'($urandom);
            model_update();
            step();
            check_outs($sformatf("rand%0d", n), m_psw, m_stk.size(), m_ovf, m_unf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
